mem_port_arbiter: RTL and testbench

//  Shares one single-port SRAM between the IF-stage fetch port and the MEM-stage

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter shared by the IF fetch port and the MEM load/store port.
// Each access runs IDLE -> ACCESS -> WAIT(SRAM_LAT) -> RESP, with a one-cycle ready pulse.
// Optional feature macro: STARVE_GUARD_EN (fetch anti-starvation counter).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned SRAM_LAT   = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              sram_cs,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               win_data;
    logic               win_we;
    logic               wait_done_c;
    logic               force_fetch_c;
    logic               grant_data_c;
    logic               launch_c;
    logic               respond_c;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Stall terms go straight to the hazard logic.
    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (if_req || d_req) next_state = ACCESS;
            ACCESS:  next_state = WAIT;
            WAIT:    if (wait_done_c) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Arbitration and per-state control strobes.
    always_comb begin
        wait_done_c  = (wait_cnt == CNT_W'(SRAM_LAT - 1));
        grant_data_c = d_req & ~(force_fetch_c & if_req);
        launch_c     = (state == IDLE) & (if_req | d_req);
        respond_c    = (state == WAIT) & wait_done_c;
    end

    // Access datapath: latch winner, drive SRAM, capture read data, pulse ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_cs    <= 1'b0;
            sram_we    <= 4'b0;
            sram_addr  <= '0;
            sram_wdata <= 32'b0;
            if_rdata   <= 32'b0;
            d_rdata    <= 32'b0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            win_data   <= 1'b0;
            win_we     <= 1'b0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            sram_cs  <= launch_c;
            sram_we  <= (launch_c && grant_data_c && d_we) ? d_wstrb : 4'b0;
            if_ready <= respond_c & ~win_data;
            d_ready  <= respond_c & win_data;
            busy     <= (next_state != IDLE);
            if (launch_c) begin
                win_data <= grant_data_c;
                win_we   <= grant_data_c & d_we;
                if (grant_data_c) begin
                    sram_addr  <= d_addr[ADDR_W+1:2];
                    sram_wdata <= d_wdata;
                end else begin
                    sram_addr  <= if_addr[ADDR_W+1:2];
                end
            end
            if (state == ACCESS) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= CNT_W'(wait_cnt + 1'b1);
            end
            if (respond_c && !win_data) begin
                if_rdata <= sram_rdata;
            end
            if (respond_c && win_data && !win_we) begin
                d_rdata <= sram_rdata;
            end
        end
    end

`ifdef STARVE_GUARD_EN
    localparam int unsigned SCNT_W = $clog2(STARVE_MAX + 1);

    logic [SCNT_W-1:0] starve_cnt;

    assign force_fetch_c = (starve_cnt == SCNT_W'(STARVE_MAX));

    // Count data wins over a waiting fetch; any fetch grant clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (launch_c) begin
            if (!grant_data_c) begin
                starve_cnt <= '0;
            end else if (if_req && (starve_cnt != SCNT_W'(STARVE_MAX))) begin
                starve_cnt <= SCNT_W'(starve_cnt + 1'b1);
            end
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = |32'(STARVE_MAX);
    assign force_fetch_c     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus contention, reset,
// starvation and long-latency sequences.
module tb_mem_port_arbiter;

`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance, SRAM_LAT = 1
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'b0;
    logic [31:0] if_rdata;
    logic        if_ready, if_stall;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = 32'b0, d_wdata = 32'b0;
    logic [3:0]  d_wstrb = 4'b0;
    logic [31:0] d_rdata;
    logic        d_ready, d_stall;
    logic        sram_cs;
    logic [3:0]  sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = BAD;
    logic        busy;

    // Second instance, SRAM_LAT = 3
    logic        d_req3 = 1'b0;
    logic [31:0] d_addr3 = 32'b0;
    logic [31:0] if_rdata3, d_rdata3, sram_wdata3;
    logic        if_ready3, if_stall3, d_ready3, d_stall3, sram_cs3, busy3;
    logic [3:0]  sram_we3;
    logic [13:0] sram_addr3;
    logic [31:0] sram_rdata3 = 32'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(14), .SRAM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(14), .SRAM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'b0), .if_rdata(if_rdata3),
        .if_ready(if_ready3), .if_stall(if_stall3),
        .d_req(d_req3), .d_we(1'b0), .d_addr(d_addr3), .d_wdata(32'b0),
        .d_wstrb(4'b0), .d_rdata(d_rdata3), .d_ready(d_ready3), .d_stall(d_stall3),
        .sram_cs(sram_cs3), .sram_we(sram_we3), .sram_addr(sram_addr3),
        .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3), .busy(busy3)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwstrb;
        logic [31:0] rdata;
        logic        exp_data;
        logic [13:0] exp_addr;
        logic [3:0]  exp_we;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_if;
    logic [31:0] exp_d;

    initial begin
        //           ireq  iaddr          dreq  dwe   daddr          dwdata         wstrb    rdata          data  addr      we
        vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0050_0093, 1'b0, 14'h0004, 4'b0000};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 32'h1111_1111, 1'b1, 14'h0041, 4'b0011};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0208, 32'h5555_5555, 4'b1111, 32'h1234_5678, 1'b1, 14'h0082, 4'b0000};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0, 14'h3FFF, 4'b0000};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0001_0007, 32'h7777_7777, 4'b0000, 32'h2222_2222, 1'b1, 14'h0001, 4'b0000};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_FFFC, 32'h0,         4'b0000, 32'h0BAD_F00D, 1'b1, 14'h3FFF, 4'b0000};

        exp_if = 32'b0;
        exp_d  = 32'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(sram_cs), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_ready", 32'({if_ready, d_ready}), 32'h0);
        rst = 1'b1;
        tick();

        // Vector table, SRAM_LAT = 1
        for (int v = 0; v < 6; v++) begin
            if_req  = vecs[v].ireq;  if_addr = vecs[v].iaddr;
            d_req   = vecs[v].dreq;  d_we    = vecs[v].dwe;
            d_addr  = vecs[v].daddr; d_wdata = vecs[v].dwdata;
            d_wstrb = vecs[v].dwstrb;
            sram_rdata = BAD;
            chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'h0);
            tick();
            chk($sformatf("v%0d_cs", v), 32'(sram_cs), 32'h1);
            chk($sformatf("v%0d_addr", v), 32'(sram_addr), 32'(vecs[v].exp_addr));
            chk($sformatf("v%0d_we", v), 32'(sram_we), 32'(vecs[v].exp_we));
            if (vecs[v].exp_data && vecs[v].dwe)
                chk($sformatf("v%0d_wdata", v), sram_wdata, vecs[v].dwdata);
            tick();
            sram_rdata = vecs[v].rdata;
            chk($sformatf("v%0d_cs_wait", v), 32'(sram_cs), 32'h0);
            tick();
            sram_rdata = BAD;
            if (vecs[v].exp_data && !vecs[v].dwe) exp_d = vecs[v].rdata;
            if (!vecs[v].exp_data) exp_if = vecs[v].rdata;
            chk($sformatf("v%0d_if_ready", v), 32'(if_ready), 32'(!vecs[v].exp_data));
            chk($sformatf("v%0d_d_ready", v), 32'(d_ready), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_if_rdata", v), if_rdata, exp_if);
            chk($sformatf("v%0d_d_rdata", v), d_rdata, exp_d);
            if_req = 1'b0;
            d_req  = 1'b0;
            tick();
            chk($sformatf("v%0d_done", v), 32'({if_ready, d_ready, busy}), 32'h0);
        end

        // Contention: data first, then the waiting fetch
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int c = 1; c <= 8; c++) begin
            tick();
            sram_rdata = (c == 2) ? 32'h0D0D_0D0D : (c == 6) ? 32'hF0F0_F0F0 : BAD;
            if (c <= 6) chk($sformatf("ct_if_stall_c%0d", c), 32'(if_stall), 32'h1);
            if (c == 1) chk("ct_data_addr", 32'({sram_cs, sram_addr}), 32'({1'b1, 14'h0020}));
            if (c == 3) begin
                chk("ct_d_ready", 32'({d_ready, if_ready}), 32'h2);
                chk("ct_d_rdata", d_rdata, 32'h0D0D_0D0D);
                d_req = 1'b0;
            end
            if (c == 4) chk("ct_idle", 32'(busy), 32'h0);
            if (c == 5) chk("ct_fetch_addr", 32'({sram_cs, sram_addr}), 32'({1'b1, 14'h0010}));
            if (c == 7) begin
                chk("ct_if_ready", 32'({if_ready, d_ready, if_stall}), 32'h4);
                chk("ct_if_rdata", if_rdata, 32'hF0F0_F0F0);
                if_req = 1'b0;
            end
        end

        // Reset during ACCESS: cs and busy drop at once, rdata cleared
        if_req = 1'b1; if_addr = 32'h44;
        tick();
        chk("ra_cs_before", 32'(sram_cs), 32'h1);
        rst = 1'b0;
        if_req = 1'b0;
        #1;
        chk("ra_cs", 32'(sram_cs), 32'h0);
        chk("ra_busy", 32'(busy), 32'h0);
        chk("ra_rdata", if_rdata | d_rdata, 32'h0);
        tick();
        rst = 1'b1;
        // Reset during WAIT: no ready pulse afterwards
        if_req = 1'b1;
        tick();
        tick();
        sram_rdata = 32'h9999_9999;
        chk("rw_busy_before", 32'(busy), 32'h1);
        rst = 1'b0;
        if_req = 1'b0;
        #1;
        chk("rw_busy", 32'(busy), 32'h0);
        tick();
        chk("rw_no_ready", 32'({if_ready, d_ready}), 32'h0);
        rst = 1'b1;
        tick();
        chk("rw_no_ready2", 32'({if_ready, d_ready, busy}), 32'h0);
        chk("rw_rdata", if_rdata, 32'h0);

        // Sustained contention: fetch only wins with the starvation guard
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk($sformatf("sv_grant%0d", g), 32'(sram_addr),
                (GUARD && g == 4) ? 32'h10 : 32'h20);
            tick();
            tick();
            tick();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        // SRAM_LAT = 3 load: data from cycle 4 returned at cycle 5
        d_req3 = 1'b1;
        d_addr3 = 32'h20;
        sram_rdata3 = 32'hA500_0000;
        for (int c = 1; c <= 6; c++) begin
            tick();
            sram_rdata3 = 32'hA500_0000 + 32'(c);
            if (c == 1) chk("l3_cs", 32'({sram_cs3, sram_addr3}), 32'({1'b1, 14'h0008}));
            chk($sformatf("l3_ready_c%0d", c), 32'(d_ready3), 32'(c == 5));
            if (c == 5) begin
                chk("l3_rdata", d_rdata3, 32'hA500_0004);
                d_req3 = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
